sh7604_rstc: RTL and testbench

SH7604_RSTC -- requirements
Module: sh7604_rstc

---
 rtl/sh7604_rstc_pkg.sv | 28 ++
 rtl/sh7604_sync2.sv | 26 ++
 rtl/sh7604_rstc.sv | 193 +++++++++++++++++++
 tb/tb_sh7604_rstc.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/sh7604_rstc_pkg.sv
// Shared types for the SH7604 reset controller: FSM state encoding, reset-cause
// codes and a saturating counter helper.
package SH7604_PKG;

    typedef enum logic [2:0] {
        RSTC_RUN      = 3'd0,
        RSTC_PIN_RST  = 3'd1,
        RSTC_WDT_PRST = 3'd2,
        RSTC_WDT_MRST = 3'd3,
        RSTC_RELEASE  = 3'd4
    } RSTC_STATE_t;

    // 2'b11 is reserved and never produced.
    localparam logic [1:0] CAUSE_PIN_POR = 2'b00;
    localparam logic [1:0] CAUSE_WDT_POR = 2'b01;
    localparam logic [1:0] CAUSE_WDT_MAN = 2'b10;

    function automatic logic [3:0] sat_dec4(input logic [3:0] val);
        logic [3:0] res;
        if (val == 4'd0) begin
            res = 4'd0;
        end else begin
            res = val - 4'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/sh7604_sync2.sv
// Two-flop synchronizer for the asynchronous external reset pin; clears to 0
// so the controller starts out seeing the pin asserted.
module sh7604_sync2 (
    input  logic CLK,
    input  logic RST_N,
    input  logic D,
    output logic Q
);

    logic meta_r;
    logic sync_r;

    // Synchronizer chain, clocked every CLK independent of any enable.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= D;
            sync_r <= meta_r;
        end
    end

    assign Q = sync_r;

endmodule

// File: rtl/sh7604_rstc.sv
// SH7604 reset controller: sequences pin and watchdog resets, holds watchdog
// resets for a prescaler-timed interval and staggers CPU release after peripherals.
module sh7604_rstc
    import SH7604_PKG::*;
#(
    parameter int unsigned HOLD_TICKS = 32'd8,
    parameter int unsigned STAGGER    = 32'd4,
    parameter int unsigned DISABLE    = 32'd0
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       CE_R,
    input  logic       EN,
    input  logic       RES_N,
    input  logic       PRES,
    input  logic       MRES,
    input  logic       CLK512_CE,
    output logic       CPU_RES_N,
    output logic       PERI_RES_N,
    output logic       WDT_RES_N,
    output logic       MAN_RST,
    output logic [1:0] RST_CAUSE,
    output logic       BUSY
);

    localparam logic        DIS       = (DISABLE != 32'd0);
    localparam logic [3:0]  HOLD_LD   = 4'(HOLD_TICKS);
    localparam logic [3:0]  STAG_LD   = 4'(STAGGER);
    localparam RSTC_STATE_t RST_STATE = DIS ? RSTC_RUN : RSTC_PIN_RST;

    logic        pin_n_s;
    logic        qual_s;
    RSTC_STATE_t state_r;
    RSTC_STATE_t state_nx_s;
    logic [3:0]  hold_cnt_r;
    logic [3:0]  hold_nx_s;
    logic [3:0]  stag_cnt_r;
    logic [3:0]  stag_nx_s;
    logic [1:0]  cause_r;
    logic [1:0]  cause_nx_s;
    logic        man_r;
    logic        man_nx_s;
    logic        cpu_nx_s;
    logic        peri_nx_s;
    logic        wdt_nx_s;
    logic        busy_nx_s;
    logic        cpu_r;
    logic        peri_r;
    logic        wdt_r;
    logic        busy_r;

    sh7604_sync2 u_sync (
        .CLK   (CLK),
        .RST_N (RST_N),
        .D     (RES_N),
        .Q     (pin_n_s)
    );

    assign qual_s = CE_R & EN;

    // Next-state, counter and cause logic, evaluated as if the cycle is qualified.
    always_comb begin
        state_nx_s = state_r;
        hold_nx_s  = hold_cnt_r;
        stag_nx_s  = stag_cnt_r;
        cause_nx_s = cause_r;
        man_nx_s   = man_r;
        if (DIS) begin
            state_nx_s = RSTC_RUN;
            hold_nx_s  = 4'd0;
            stag_nx_s  = 4'd0;
            cause_nx_s = CAUSE_PIN_POR;
            man_nx_s   = 1'b0;
        end else if (!pin_n_s) begin
            // Pin reset overrides everything and abandons any count in progress.
            state_nx_s = RSTC_PIN_RST;
            hold_nx_s  = 4'd0;
            stag_nx_s  = 4'd0;
            cause_nx_s = CAUSE_PIN_POR;
            man_nx_s   = 1'b0;
        end else begin
            case (state_r)
                RSTC_RUN: begin
                    if (PRES) begin
                        state_nx_s = RSTC_WDT_PRST;
                        hold_nx_s  = HOLD_LD;
                        cause_nx_s = CAUSE_WDT_POR;
                        man_nx_s   = 1'b0;
                    end else if (MRES) begin
                        state_nx_s = RSTC_WDT_MRST;
                        hold_nx_s  = HOLD_LD;
                        cause_nx_s = CAUSE_WDT_MAN;
                        man_nx_s   = 1'b1;
                    end else begin
                        state_nx_s = RSTC_RUN;
                    end
                end
                RSTC_PIN_RST: begin
                    state_nx_s = RSTC_RELEASE;
                    stag_nx_s  = STAG_LD;
                end
                RSTC_WDT_PRST, RSTC_WDT_MRST: begin
                    if (CLK512_CE) begin
                        hold_nx_s = sat_dec4(hold_cnt_r);
                    end else begin
                        hold_nx_s = hold_cnt_r;
                    end
                    if (hold_nx_s == 4'd0) begin
                        state_nx_s = RSTC_RELEASE;
                        stag_nx_s  = STAG_LD;
                    end else begin
                        state_nx_s = state_r;
                    end
                end
                RSTC_RELEASE: begin
                    stag_nx_s = sat_dec4(stag_cnt_r);
                    if (stag_nx_s == 4'd0) begin
                        state_nx_s = RSTC_RUN;
                    end else begin
                        state_nx_s = RSTC_RELEASE;
                    end
                end
                default: begin
                    state_nx_s = RSTC_PIN_RST;
                    hold_nx_s  = 4'd0;
                    stag_nx_s  = 4'd0;
                end
            endcase
        end
    end

    // Reset-line decode from the next state so outputs register alongside the state.
    always_comb begin
        cpu_nx_s  = 1'b0;
        peri_nx_s = 1'b0;
        wdt_nx_s  = 1'b0;
        busy_nx_s = 1'b1;
        case (state_nx_s)
            RSTC_RUN: begin
                cpu_nx_s  = 1'b1;
                peri_nx_s = 1'b1;
                wdt_nx_s  = 1'b1;
                busy_nx_s = 1'b0;
            end
            RSTC_WDT_PRST: begin
                wdt_nx_s = 1'b1;
            end
            RSTC_WDT_MRST, RSTC_RELEASE: begin
                peri_nx_s = 1'b1;
                wdt_nx_s  = 1'b1;
            end
            default: begin
                cpu_nx_s  = 1'b0;
                peri_nx_s = 1'b0;
                wdt_nx_s  = 1'b0;
                busy_nx_s = 1'b1;
            end
        endcase
    end

    // State, counters and registered outputs; advance only on qualified cycles.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r    <= RST_STATE;
            hold_cnt_r <= 4'd0;
            stag_cnt_r <= 4'd0;
            cause_r    <= CAUSE_PIN_POR;
            man_r      <= 1'b0;
            cpu_r      <= DIS;
            peri_r     <= DIS;
            wdt_r      <= DIS;
            busy_r     <= ~DIS;
        end else if (qual_s) begin
            state_r    <= state_nx_s;
            hold_cnt_r <= hold_nx_s;
            stag_cnt_r <= stag_nx_s;
            cause_r    <= cause_nx_s;
            man_r      <= man_nx_s;
            cpu_r      <= cpu_nx_s;
            peri_r     <= peri_nx_s;
            wdt_r      <= wdt_nx_s;
            busy_r     <= busy_nx_s;
        end
    end

    assign CPU_RES_N  = cpu_r;
    assign PERI_RES_N = peri_r;
    assign WDT_RES_N  = wdt_r;
    assign MAN_RST    = man_r;
    assign RST_CAUSE  = cause_r;
    assign BUSY       = busy_r;

endmodule

// File: tb/tb_sh7604_rstc.sv
// Directed bench for the SH7604 reset controller with default parameters.
module tb_sh7604_rstc;

    logic       CLK;
    logic       RST_N;
    logic       CE_R;
    logic       EN;
    logic       RES_N;
    logic       PRES;
    logic       MRES;
    logic       CLK512_CE;
    logic       CPU_RES_N;
    logic       PERI_RES_N;
    logic       WDT_RES_N;
    logic       MAN_RST;
    logic [1:0] RST_CAUSE;
    logic       BUSY;

    int n_cmp = 0;
    int n_err = 0;

    sh7604_rstc dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .CE_R       (CE_R),
        .EN         (EN),
        .RES_N      (RES_N),
        .PRES       (PRES),
        .MRES       (MRES),
        .CLK512_CE  (CLK512_CE),
        .CPU_RES_N  (CPU_RES_N),
        .PERI_RES_N (PERI_RES_N),
        .WDT_RES_N  (WDT_RES_N),
        .MAN_RST    (MAN_RST),
        .RST_CAUSE  (RST_CAUSE),
        .BUSY       (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_rst(input string tag, input logic cpu, input logic peri, input logic wdt);
        chk({tag, ".cpu"},  {1'b0, CPU_RES_N},  {1'b0, cpu});
        chk({tag, ".peri"}, {1'b0, PERI_RES_N}, {1'b0, peri});
        chk({tag, ".wdt"},  {1'b0, WDT_RES_N},  {1'b0, wdt});
    endtask

    task automatic chk_tag(input string tag, input logic man, input logic [1:0] cause, input logic busy);
        chk({tag, ".man"},   {1'b0, MAN_RST}, {1'b0, man});
        chk({tag, ".cause"}, RST_CAUSE,       cause);
        chk({tag, ".busy"},  {1'b0, BUSY},    {1'b0, busy});
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        RST_N = 1'b0; RES_N = 1'b0; CE_R = 1'b1; EN = 1'b1;
        PRES = 1'b0; MRES = 1'b0; CLK512_CE = 1'b0;
        cyc(3);
        chk_rst("reset", 1'b0, 1'b0, 1'b0);
        chk_tag("reset", 1'b0, 2'b00, 1'b1);

        // Pin reset held after RST_N release, then pin rises.
        RST_N = 1'b1;
        cyc(20);
        chk_rst("pin_hold", 1'b0, 1'b0, 1'b0);
        chk("pin_hold.busy", {1'b0, BUSY}, 2'b01);
        RES_N = 1'b1;
        cyc(2);
        chk("pin_peri_early", {1'b0, PERI_RES_N}, 2'b00);
        cyc(1);
        chk_rst("pin_release", 1'b0, 1'b1, 1'b1);
        cyc(3);
        chk("pin_cpu_early", {1'b0, CPU_RES_N}, 2'b00);
        cyc(1);
        chk_rst("pin_run", 1'b1, 1'b1, 1'b1);
        chk_tag("pin_run", 1'b0, 2'b00, 1'b0);

        // Watchdog power-on reset, 8 ticks with gaps and a CE_R-gated stretch.
        PRES = 1'b1; cyc(1); PRES = 1'b0;
        chk_rst("pres_entry", 1'b0, 1'b0, 1'b1);
        chk_tag("pres_entry", 1'b0, 2'b01, 1'b1);
        for (int i = 0; i < 7; i++) begin
            CLK512_CE = 1'b1; cyc(1);
            CLK512_CE = 1'b0; cyc(1);
        end
        chk_rst("pres_hold7", 1'b0, 1'b0, 1'b1);
        CE_R = 1'b0; CLK512_CE = 1'b1; cyc(3);
        CE_R = 1'b1; CLK512_CE = 1'b0; cyc(1);
        chk_rst("pres_ce_gate", 1'b0, 1'b0, 1'b1);
        CLK512_CE = 1'b1; cyc(1); CLK512_CE = 1'b0;
        chk_rst("pres_release", 1'b0, 1'b1, 1'b1);
        cyc(3);
        chk("pres_cpu_early", {1'b0, CPU_RES_N}, 2'b00);
        cyc(1);
        chk_rst("pres_run", 1'b1, 1'b1, 1'b1);
        chk_tag("pres_run", 1'b0, 2'b01, 1'b0);

        // Watchdog manual reset; MRES during RELEASE must be ignored.
        MRES = 1'b1; cyc(1); MRES = 1'b0;
        chk_rst("mres_entry", 1'b0, 1'b1, 1'b1);
        chk_tag("mres_entry", 1'b1, 2'b10, 1'b1);
        CLK512_CE = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cyc(1);
            chk_rst("mres_hold", 1'b0, 1'b1, 1'b1);
        end
        cyc(1); CLK512_CE = 1'b0;
        MRES = 1'b1; cyc(3);
        chk_rst("mres_ign", 1'b0, 1'b1, 1'b1);
        MRES = 1'b0; cyc(1);
        chk_rst("mres_run", 1'b1, 1'b1, 1'b1);
        chk_tag("mres_run", 1'b1, 2'b10, 1'b0);
        cyc(2);
        chk_rst("mres_no_retrig", 1'b1, 1'b1, 1'b1);
        chk("mres_no_retrig.busy", {1'b0, BUSY}, 2'b00);

        // PRES and MRES together: power-on wins.
        PRES = 1'b1; MRES = 1'b1; cyc(1); PRES = 1'b0; MRES = 1'b0;
        chk_rst("both_entry", 1'b0, 1'b0, 1'b1);
        chk_tag("both_entry", 1'b0, 2'b01, 1'b1);
        CLK512_CE = 1'b1; cyc(8); CLK512_CE = 1'b0;
        chk_rst("both_release", 1'b0, 1'b1, 1'b1);
        cyc(4);
        chk_rst("both_run", 1'b1, 1'b1, 1'b1);
        chk("both_run.busy", {1'b0, BUSY}, 2'b00);

        // Pin reset aborts a manual hold at tick 3.
        MRES = 1'b1; cyc(1); MRES = 1'b0;
        CLK512_CE = 1'b1; cyc(3);
        RES_N = 1'b0; cyc(2);
        chk_rst("abort_pre", 1'b0, 1'b1, 1'b1);
        cyc(1); CLK512_CE = 1'b0;
        chk_rst("abort_pin", 1'b0, 1'b0, 1'b0);
        chk_tag("abort_pin", 1'b0, 2'b00, 1'b1);

        // EN low freezes the FSM while the synchronizer still follows the pin.
        EN = 1'b0; RES_N = 1'b1; cyc(6);
        chk_rst("en_gate", 1'b0, 1'b0, 1'b0);
        EN = 1'b1; cyc(1);
        chk_rst("en_release", 1'b0, 1'b1, 1'b1);
        cyc(3);
        chk("en_cpu_early", {1'b0, CPU_RES_N}, 2'b00);
        cyc(1);
        chk_rst("final_run", 1'b1, 1'b1, 1'b1);
        chk_tag("final_run", 1'b0, 2'b00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
